uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 33 +++
 rtl/baud_tick_gen.sv | 52 +++++
 rtl/uart_rx.sv | 185 ++++++++++++++++++
 tb/tb_uart_rx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path (and the matching transmitter):
//   - uart_state_e : 3-bit receiver state encoding
//   - DATA_BITS    : data bits per frame
//   - STOP_BITS    : stop bits per frame
//   - calc_div     : system clocks per oversample tick
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Clocks per sample tick, truncated. Clamped to 1 so an over-fast baud
    // setting still yields a legal (every-clock) tick instead of a zero divider.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        int d;
        d = clk_freq / (baud * oversample);
        if (d < 1) begin
            d = 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// -----------------------------------------------------------------------------
// baud_tick_gen
// Free-running divider producing a one-clock sample tick every
// CLK_FREQ/(BAUD*OVERSAMPLE) clocks. Shared by the UART receiver and
// transmitter.
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   tick  : one-clock pulse at the oversample rate (registered)
// -----------------------------------------------------------------------------
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q + CW'(1);
        tick_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver with oversampled mid-bit sampling, glitch rejection on the
// start bit and break handling after a bad stop bit.
//
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   RsRx       : asynchronous serial line, idle high
//   data       : last correctly framed byte (held until the next good frame)
//   data_valid : one-clock pulse when data updates
//   frame_err  : one-clock pulse when the stop bit samples low
//   busy       : high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RsRx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = $clog2(DATA_BITS);

    // Mid start bit is one tick earlier than half a bit because the tick that
    // first sees the low line already counts as tick 0.
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic tick;

    baud_tick_gen #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Two-flop synchronizer, reset to the idle (high) line level so a reset
    // release never looks like a start edge.
    logic sync1_q, sync2_q;
    logic rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= RsRx;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    uart_state_e          state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [7:0]           data_q, data_d;
    logic                 data_valid_q, data_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 busy_q, busy_d;

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tick && !rx_s) begin
                    state_d    = ST_START;
                    tick_cnt_d = '0;
                end
            end

            ST_START: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_HALF) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        // A line already back high at mid start bit was noise.
                        state_d    = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end

            ST_DATA: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        // LSB arrives first, so shifting right lands it in bit 0.
                        shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d  = bit_cnt_q + BW'(1);
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = ST_STOP;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end

            ST_STOP: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        if (rx_s) begin
                            data_d       = shift_q;
                            data_valid_d = 1'b1;
                            state_d      = ST_IDLE;
                        end else begin
                            frame_err_d  = 1'b1;
                            state_d      = ST_BREAK;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end

            ST_BREAK: begin
                // Wait out a held-low line so it is not mistaken for a new start bit.
                if (tick && rx_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered from the next state so busy lines up with state_q.
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            data_q       <= 8'h00;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx at CLK_FREQ=1.6 MHz, BAUD=10 kbit/s,
// OVERSAMPLE=16 (160 clocks per bit). A monitor logs every data_valid byte
// and frame_err pulse; a frame-level model records which bytes and errors
// each stimulus must produce, and the two are compared after each scenario.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CLK_FREQ   = 1600000;
    localparam int BAUD       = 10000;
    localparam int OVERSAMPLE = 16;
    localparam int BIT_CLKS   = CLK_FREQ / BAUD;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       RsRx  = 1'b1;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    uart_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RsRx       (RsRx),
        .data       (data),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Output monitor, sampled on the falling edge.
    logic [7:0] got_arr [0:255];
    int         got_n    = 0;
    int         fe_n     = 0;
    int         both_n   = 0;
    int         hold_bad = 0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_data <= 8'h00;
        end else begin
            if (data_valid) begin
                got_arr[got_n[7:0]] <= data;
                got_n <= got_n + 1;
            end
            if (frame_err) begin
                fe_n <= fe_n + 1;
            end
            if (data_valid && frame_err) begin
                both_n <= both_n + 1;
            end
            if (!data_valid && (data !== prev_data)) begin
                hold_bad <= hold_bad + 1;
            end
            prev_data <= data;
        end
    end

    // Frame-level reference model state.
    logic [7:0] exp_q [$];
    int         exp_fe   = 0;
    logic [7:0] exp_last = 8'h00;
    int         base_dv  = 0;
    int         base_fe  = 0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic line_bit(input logic v, input int n);
        RsRx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        line_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            line_bit(b[i], BIT_CLKS);
        end
        line_bit(stop, BIT_CLKS);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, 1'b1);
        exp_q.push_back(b);
        exp_last = b;
    endtask

    task automatic send_bad(input logic [7:0] b);
        send_frame(b, 1'b0);
        exp_fe++;
    endtask

    // Compare everything the monitor saw since the last flush against the model.
    task automatic flush(input string tag);
        int n_got;
        n_got = got_n - base_dv;
        chk({tag, ".n_dv"}, 32'(n_got), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n_got; i++) begin
            chk({tag, ".byte"}, 32'(got_arr[base_dv + i]), 32'(exp_q[i]));
        end
        chk({tag, ".n_fe"}, 32'(fe_n - base_fe), 32'(exp_fe));
        chk({tag, ".data"}, 32'(data), 32'(exp_last));
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".both"}, 32'(both_n), 32'd0);
        chk({tag, ".hold"}, 32'(hold_bad), 32'd0);
        base_dv = got_n;
        base_fe = fe_n;
        exp_q.delete();
        exp_fe = 0;
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] rst_byte;
        int         kind;
        int         gap;

        rst_n = 1'b0;
        RsRx  = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst.data", 32'(data), 32'h00);
        chk("rst.dv",   32'(data_valid), 32'd0);
        chk("rst.fe",   32'(frame_err), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);

        rst_n = 1'b1;
        line_bit(1'b1, 50);

        // Single clean frame.
        send_good(8'hA5);
        line_bit(1'b1, 40);
        flush("a5");

        // 40-clock low glitch must be rejected at mid start bit.
        line_bit(1'b0, 40);
        line_bit(1'b1, 300);
        flush("glitch");

        // Bad stop bit, line held low 400 clocks: one error, stays busy in break.
        send_bad(8'h3C);
        line_bit(1'b0, 400 - BIT_CLKS);
        chk("break.busy", 32'(busy), 32'd1);
        chk("break.data", 32'(data), 32'(exp_last));
        line_bit(1'b1, 50);
        flush("break");
        send_good(8'h81);
        flush("after_break");

        // Back-to-back frames with a single stop bit.
        send_good(8'h00);
        send_good(8'hFF);
        flush("b2b");

        // Reset in the middle of data bit 4 of 0x55.
        rst_byte = 8'h55;
        line_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            line_bit(rst_byte[i], BIT_CLKS);
        end
        line_bit(rst_byte[4], BIT_CLKS / 2);
        chk("midrst.busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst.data", 32'(data), 32'h00);
        chk("midrst.dv",   32'(data_valid), 32'd0);
        chk("midrst.fe",   32'(frame_err), 32'd0);
        chk("midrst.busy", 32'(busy), 32'd0);
        exp_last = 8'h00;
        RsRx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        line_bit(1'b1, 100);
        send_good(8'hC3);
        flush("after_rst");

        // Randomized mix of good frames, bad stop bits and short glitches.
        for (int it = 0; it < 16; it++) begin
            kind = int'($urandom_range(0, 9));
            b    = 8'($urandom_range(0, 255));
            if (kind == 0) begin
                line_bit(1'b0, int'($urandom_range(5, 50)));
                line_bit(1'b1, 200);
                flush("rnd_glitch");
            end else if (kind == 1) begin
                send_bad(b);
                line_bit(1'b1, 50);
                flush("rnd_bad");
            end else begin
                send_good(b);
                flush("rnd_good");
                gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 300));
                line_bit(1'b1, gap);
            end
        end

        line_bit(1'b1, 50);
        flush("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
